cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the `_6502` core bus. It answers CPU reads and writes from a synchronous single-port RAM with read-new-data behaviour. It also owns the CPU's reset line, so a host-side byte loader can deposit a program image into RAM while the core is held in reset. It sits between `_6502` (`ab`, `do`, `we`, `di`) and the board- or bench-level program source, and replaces ad-hoc RAM arrays in simulation and synthesis.

## Interface
Parameters:
- `ADDR_W`, default 16: RAM address width; depth is 2^ADDR_W bytes.
- `RESET_HOLD`, default 4: cycles `cpu_reset` stays high after a load or clear completes; must be at least 1.
- `CLEAR_ON_RESET`, default 0: when 1, RAM is zero-filled after reset before the CPU is released.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ab` in ADDR_W: CPU address.
- `cpu_do` in 8: CPU write data; connects to the core's `do`.
- `we` in 1: CPU write enable.
- `di` out 8: CPU read data; connects to the core's `di`.
- `cpu_reset` out 1: drives the core's `reset`.
- `ld_start` in 1: one-cycle pulse that starts a load.
- `ld_addr` in ADDR_W: load base address, sampled with `ld_start`.
- `ld_count` in ADDR_W+1: number of bytes to load, sampled with `ld_start`; range 0 to 2^ADDR_W.
- `ld_valid` in 1: load byte valid.
- `ld_data` in 8: load byte.
- `ld_ready` out 1: responder accepts the load byte this cycle.
- `ld_busy` out 1: high in the CLEAR, LOAD and HOLD states.
- `ld_done` out 1: one-cycle pulse on entering RUN from HOLD.

## Operation
- FSM states: CLEAR, RUN, LOAD, HOLD.
- On `reset`:
  - State goes to CLEAR if `CLEAR_ON_RESET`=1, otherwise to HOLD.
  - `cpu_reset`=1, `ld_ready`=0, `ld_done`=0, `ld_busy`=1, `addr_reg`=0.
  - Hold counter is loaded with `RESET_HOLD`.
  - RAM contents are not altered by `reset` itself.
- CLEAR:
  - Writes 0 to `ptr` (starting at 0), one byte per cycle, 2^ADDR_W cycles.
  - After writing the last address, goes to HOLD.
- HOLD:
  - `cpu_reset`=1; counter decrements each cycle.
  - When the counter reaches 0, goes to RUN, pulses `ld_done` for one cycle, and drops `cpu_reset` in the same cycle.
- RUN:
  - `cpu_reset`=0.
  - If `we`=1, `ram[ab] <= cpu_do`.
  - `ld_start`=1 samples `ld_addr` into `ptr` and `ld_count` into `remaining`, then goes to LOAD (or to HOLD if `ld_count`=0).
- LOAD:
  - `cpu_reset`=1 and `ld_ready`=1; CPU `we` is ignored.
  - On `ld_valid && ld_ready`: write `ram[ptr] <= ld_data`, then `ptr <= ptr+1` modulo 2^ADDR_W (0xFFFF wraps to 0x0000), then `remaining <= remaining-1`.
  - The accept that brings `remaining` to 0 moves the FSM to HOLD; `ld_ready` is 0 from the next cycle.
- `ld_start` outside RUN is ignored, with no queuing.
- `reset` asserted mid-LOAD or mid-CLEAR aborts the operation. Bytes already written remain in RAM, and the sequence restarts as after any reset.
- A simultaneous `ld_start` and CPU `we` in RUN: the CPU write completes this cycle and LOAD begins next cycle.

## Timing
- `addr_reg <= ab` every cycle in every state.
- `di = ram[addr_reg]` is combinational from the registered address. A read of an address written on the previous edge returns the new data.
- Read latency: the address presented at edge N gives valid `di` after edge N, usable by the core before edge N+1.
- Write latency: the byte is in RAM after the edge where `we` was sampled high.
- Load throughput: one byte per cycle when `ld_valid` is held high.
  - A load of n bytes takes n accept cycles, then `RESET_HOLD` cycles in HOLD.
  - The `ld_done` pulse falls in the cycle after the hold counter expires.
- CLEAR duration: 2^ADDR_W cycles, then `RESET_HOLD`.

## Configuration
- `LOAD_CHECKSUM_EN` defined:
  - Adds output `ld_sum` (8 bits), cleared to 0 on `reset` and on an accepted `ld_start`.
  - Adds each accepted `ld_data` modulo 256.
  - Holds its value after `ld_done` until the next start or reset.
- `LOAD_CHECKSUM_EN` undefined: the `ld_sum` port and its logic do not exist; all other behaviour is identical.

## Test plan
- Reset with `CLEAR_ON_RESET`=0 and `RESET_HOLD`=4 -> `cpu_reset` is high for exactly 4 cycles after `reset` falls, then `ld_done` pulses once and `cpu_reset`=0.
- Load `ld_addr`=0x0000, `ld_count`=54 with the ADC/INX/INC/DEC program bytes (0x38, 0xA9, 0x23, ...), `ld_valid` held high -> 54 accepts, then HOLD, then RUN; the core executes the program and `ram[0x55]` ends at 0xFD after 5 INC and 8 DEC.
- CPU writes 0x77 to 0x0324 at edge N and reads 0x0324 at edge N+1 -> `di`=0x77.
- Load `ld_addr`=0xFFFE, `ld_count`=3, data 0x11/0x22/0x33 -> `ram[0xFFFE]`=0x11, `ram[0xFFFF]`=0x22, `ram[0x0000]`=0x33; with `LOAD_CHECKSUM_EN`, `ld_sum`=0x66.
- `ld_valid` toggled every other cycle, `ld_count`=4; `ld_start` re-pulsed mid-load; `we`=1 during LOAD -> exactly 4 bytes written, second start ignored, no CPU writes land.
- `reset` after 2 of 5 load bytes -> the 2 bytes persist, `ld_ready` is 0 next cycle, and the HOLD/RUN sequence completes with no `ld_done` before the hold expires.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//
// Memory-side responder for the _6502 core bus. It serves CPU reads and
// writes from a single-port RAM. A write is visible to a read on the next
// edge. The block also owns the core's reset line, so a host-side byte
// loader can deposit a program image while the core is held in reset.
//
// Parameters:
//   ADDR_W         RAM address width (depth 2^ADDR_W bytes)
//   RESET_HOLD     cycles cpu_reset stays high after a load/clear (>= 1)
//   CLEAR_ON_RESET 1: zero-fill RAM after reset before releasing the CPU
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ab, cpu_do, we  CPU address, write data, write enable
//   di              CPU read data, ram[addr_reg], where addr_reg holds ab from the last edge
//   cpu_reset       drives the core's reset (high outside RUN)
//   ld_start        one-cycle pulse; samples ld_addr/ld_count (RUN only)
//   ld_addr         load base address
//   ld_count        byte count, 0..2^ADDR_W
//   ld_valid        load byte valid
//   ld_data         load byte
//   ld_ready        responder accepts the load byte this cycle (LOAD state)
//   ld_busy         high in CLEAR, LOAD and HOLD
//   ld_done         one-cycle pulse on entering RUN from HOLD
//   ld_sum          (only with LOAD_CHECKSUM_EN) mod-256 sum of loaded bytes
//
// Optional feature macro: LOAD_CHECKSUM_EN
module cpu_mem_responder #(
  parameter int ADDR_W         = 16,
  parameter int RESET_HOLD     = 4,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ab,
  input  logic [7:0]        cpu_do,
  input  logic              we,
  output logic [7:0]        di,
  output logic              cpu_reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0]        ld_sum
`endif
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HW    = $clog2(RESET_HOLD + 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [HW-1:0]     hold_cnt;
  logic [7:0]        ram [DEPTH];

  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [7:0]        ram_wd;

  assign accept    = (state == S_LOAD) && ld_valid;
  assign cpu_reset = (state != S_RUN);
  assign ld_busy   = (state != S_RUN);
  assign ld_ready  = (state == S_LOAD);
  assign di        = ram[addr_reg];

  // One write port shared by clear, loader and CPU; the state selects the
  // source. Reset blocks the write so RAM survives an aborted load or clear.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = ab;
    ram_wd = cpu_do;
    case (state)
      S_CLEAR: begin
        ram_we = 1'b1;
        ram_wa = ptr;
        ram_wd = '0;
      end
      S_LOAD: begin
        ram_we = accept;
        ram_wa = ptr;
        ram_wd = ld_data;
      end
      S_RUN:   ram_we = we;
      default: ram_we = 1'b0;
    endcase
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_HOLD;
      hold_cnt  <= HW'(RESET_HOLD);
      ptr       <= '0;
      remaining <= '0;
      addr_reg  <= '0;
      ld_done   <= 1'b0;
    end else begin
      addr_reg <= ab;
      ld_done  <= 1'b0;
      case (state)
        S_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == '1) begin
            state    <= S_HOLD;
            hold_cnt <= HW'(RESET_HOLD);
          end
        end
        // HOLD lasts exactly RESET_HOLD cycles: release happens on the
        // edge that would take the counter from 1 to 0.
        S_HOLD: begin
          if (hold_cnt <= HW'(1)) begin
            state   <= S_RUN;
            ld_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        S_RUN: begin
          if (ld_start) begin
            ptr       <= ld_addr;
            remaining <= ld_count;
            hold_cnt  <= HW'(RESET_HOLD);
            state     <= (ld_count == '0) ? S_HOLD : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
            if (remaining == (ADDR_W + 1)'(1)) begin
              state    <= S_HOLD;
              hold_cnt <= HW'(RESET_HOLD);
            end
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_sum <= '0;
    end else if ((state == S_RUN) && ld_start) begin
      ld_sum <= '0;
    end else if (accept) begin
      ld_sum <= ld_sum + ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: 64 KiB, RESET_HOLD 4, no clear.
  logic        reset = 1'b1;
  logic [15:0] ab = '0;
  logic [7:0]  cpu_do = '0;
  logic        we = 1'b0;
  logic [7:0]  di;
  logic        cpu_reset;
  logic        ld_start = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [16:0] ld_count = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, ld_busy, ld_done;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  ld_sum;
`endif

  // Small DUT with clear-on-reset: 16 bytes, RESET_HOLD 2.
  logic        reset1 = 1'b1;
  logic [3:0]  ab1 = '0;
  logic [7:0]  cpu_do1 = '0;
  logic        we1 = 1'b0;
  logic [7:0]  di1;
  logic        cpu_reset1;
  logic        ld_start1 = 1'b0;
  logic [3:0]  ld_addr1 = '0;
  logic [4:0]  ld_count1 = '0;
  logic        ld_valid1 = 1'b0;
  logic [7:0]  ld_data1 = '0;
  logic        ld_ready1, ld_busy1, ld_done1;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  ld_sum1;
`endif

  cpu_mem_responder #(.ADDR_W(16), .RESET_HOLD(4), .CLEAR_ON_RESET(0)) u0 (
    .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di),
    .cpu_reset(cpu_reset), .ld_start(ld_start), .ld_addr(ld_addr),
    .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
`ifdef LOAD_CHECKSUM_EN
    , .ld_sum(ld_sum)
`endif
  );

  cpu_mem_responder #(.ADDR_W(4), .RESET_HOLD(2), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset1), .ab(ab1), .cpu_do(cpu_do1), .we(we1), .di(di1),
    .cpu_reset(cpu_reset1), .ld_start(ld_start1), .ld_addr(ld_addr1),
    .ld_count(ld_count1), .ld_valid(ld_valid1), .ld_data(ld_data1),
    .ld_ready(ld_ready1), .ld_busy(ld_busy1), .ld_done(ld_done1)
`ifdef LOAD_CHECKSUM_EN
    , .ld_sum(ld_sum1)
`endif
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [int];
  logic [7:0] byte_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    ab = a; cpu_do = d; we = 1'b1;
    tick();
    we = 1'b0;
    model[int'(a)] = d;
  endtask

  task automatic cpu_read(input logic [15:0] a, input string tag);
    exp_t e;
    ab = a; we = 1'b0;
    e.tag = tag;
    e.exp = model.exists(int'(a)) ? model[int'(a)] : 8'h00;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check(e.tag, di, e.exp);
  endtask

  // Waits for cpu_reset to drop; HOLD must last 4 cycles, ld_done must
  // appear only at release and last one cycle.
  task automatic expect_release(input string tag);
    int cyc = 0;
    int early = 0;
    while (cpu_reset && cyc < 200) begin
      if (ld_done) early++;
      tick();
      cyc++;
    end
    check({tag, "_hold_cycles"}, cyc, 4);
    check({tag, "_early_done"}, early, 0);
    check({tag, "_done_pulse"}, ld_done, 1);
    check({tag, "_busy_run"}, ld_busy, 0);
    tick();
    check({tag, "_done_low"}, ld_done, 0);
  endtask

  // mode 0: ld_valid held high. mode 1: ld_valid toggled, a second ld_start
  // mid-load and CPU writes attempted throughout.
  task automatic load(input logic [15:0] base, input int n, input int mode, input string tag);
    int         acc = 0;
    int         cyc = 0;
    logic [15:0] p = base;
    logic [7:0]  sum = '0;
    logic        took;
    ld_addr = base; ld_count = 17'(n); ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check({tag, "_ready"}, ld_ready, 1);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    while (acc < n && cyc < 400) begin
      ld_valid = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      ld_data  = byte_q[acc];
      if (mode == 1) begin
        we = 1'b1; ab = 16'h0400; cpu_do = 8'hEE;
        ld_start = (cyc == 2);
        if (cyc == 2) begin
          ld_addr = 16'h0300; ld_count = 17'd1;
        end
      end
      took = ld_valid && ld_ready;
      tick();
      if (took) begin
        model[int'(p)] = ld_data;
        sum += ld_data;
        p++;
        acc++;
      end
      cyc++;
    end
    ld_valid = 1'b0; we = 1'b0; ld_start = 1'b0;
    check({tag, "_accepts"}, acc, n);
    check({tag, "_cycles"}, cyc, (mode == 0) ? n : 2 * n - 1);
    check({tag, "_ready_off"}, ld_ready, 0);
    expect_release(tag);
`ifdef LOAD_CHECKSUM_EN
    check({tag, "_sum"}, ld_sum, sum);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    exp_t e;

    // Reset state and release timing.
    repeat (3) tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ready", ld_ready, 0);
    check("rst_busy", ld_busy, 1);
    check("rst_done", ld_done, 0);
`ifdef LOAD_CHECKSUM_EN
    check("rst_sum", ld_sum, 0);
`endif
    reset = 1'b0;
    expect_release("rst");

    // Write at edge N, read back at edge N+1.
    cpu_write(16'h0324, 8'h77);
    cpu_read(16'h0324, "wr_rd_0324");

    // Program image load at 0x0000.
    byte_q = {};
    byte_q.push_back(8'h38); byte_q.push_back(8'hA9); byte_q.push_back(8'h23);
    for (int i = 3; i < 54; i++) byte_q.push_back(8'((i * 37 + 11) & 255));
    load(16'h0000, 54, 0, "prog");
    for (int i = 0; i < 54; i++) cpu_read(16'(i), $sformatf("prog_rd_%0d", i));

    // Address wrap at top of memory.
    byte_q = {8'h11, 8'h22, 8'h33};
    load(16'hFFFE, 3, 0, "wrap");
    cpu_read(16'hFFFE, "wrap_fffe");
    cpu_read(16'hFFFF, "wrap_ffff");
    cpu_read(16'h0000, "wrap_0000");
`ifdef LOAD_CHECKSUM_EN
    check("wrap_sum_66", ld_sum, 8'h66);
`endif

    // Throttled load with ignored restart and ignored CPU writes.
    cpu_write(16'h0204, 8'h5A);
    cpu_write(16'h0300, 8'h99);
    cpu_write(16'h0400, 8'h01);
    byte_q = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load(16'h0200, 4, 1, "thr");
    for (int i = 0; i < 5; i++) cpu_read(16'h0200 + 16'(i), $sformatf("thr_rd_%0d", i));
    cpu_read(16'h0300, "thr_no_restart");
    cpu_read(16'h0400, "thr_no_cpu_wr");

    // Zero-length load goes straight to HOLD.
    ld_addr = 16'h0600; ld_count = '0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("zero_busy", ld_busy, 1);
    check("zero_ready", ld_ready, 0);
    expect_release("zero");

    // Reset after 2 of 5 bytes.
    for (int i = 0; i < 5; i++) cpu_write(16'h0500 + 16'(i), 8'h00);
    ld_addr = 16'h0500; ld_count = 17'd5; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 8'hA1; tick(); model[16'h0500] = 8'hA1;
    ld_data = 8'hA2; tick(); model[16'h0501] = 8'hA2;
    ld_data = 8'hA3; reset = 1'b1;
    tick();
    check("abort_ready", ld_ready, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    reset = 1'b0; ld_valid = 1'b0;
    expect_release("abort");
`ifdef LOAD_CHECKSUM_EN
    check("abort_sum", ld_sum, 0);
`endif
    for (int i = 0; i < 5; i++) cpu_read(16'h0500 + 16'(i), $sformatf("abort_rd_%0d", i));

    // Clear-on-reset instance: 16 clear cycles + 2 hold cycles.
    reset1 = 1'b0;
    cyc = 0;
    while (cpu_reset1 && cyc < 200) begin tick(); cyc++; end
    check("clr_release_cycles", cyc, 18);
    ab1 = 4'd5; cpu_do1 = 8'hC3; we1 = 1'b1;
    tick();
    we1 = 1'b0;
    e.tag = "clr_wr_rd"; e.exp = 8'hC3; sb.push_back(e);
    tick();
    e = sb.pop_front();
    check(e.tag, di1, e.exp);
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    cyc = 0;
    while (cpu_reset1 && cyc < 200) begin tick(); cyc++; end
    check("clr_release_cycles2", cyc, 18);
    ab1 = 4'd5;
    e.tag = "clr_zeroed"; e.exp = 8'h00; sb.push_back(e);
    tick();
    e = sb.pop_front();
    check(e.tag, di1, e.exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
